// File: rtl/nano_pkg.sv
// Shared constants and types for the NanoCPU program loader and its memory.
package nano_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_HI = 2'd1,
    LOAD_LO = 2'd2,
    RUN     = 2'd3
  } loader_state_t;

  typedef logic [DATA_W-1:0] mem_word_t;
endpackage

// File: rtl/nano_loader_mem_if.sv
// Load-stream handshake, status and CPU bus signals of nano_loader_mem.
interface nano_loader_mem_if;
  import nano_pkg::*;

  logic              load_start;
  logic              run;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              busy;
  logic              done;
  logic              cpu_rst;
  logic [ADDR_W-1:0] address;
  mem_word_t         dataW;
  logic              ce;
  logic              we;
  mem_word_t         dataR;

  modport slave (
    input  load_start, run, byte_in, byte_valid, address, dataW, ce, we,
    output byte_ready, busy, done, cpu_rst, dataR
  );

  modport master (
    output load_start, run, byte_in, byte_valid, address, dataW, ce, we,
    input  byte_ready, busy, done, cpu_rst, dataR
  );
endinterface

// File: rtl/nano_ram.sv
// Word storage: one synchronous write port, asynchronous read, contents survive reset.
module nano_ram
  import nano_pkg::*;
(
  input  logic              ck,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  mem_word_t         i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output mem_word_t         o_rdata
);

  mem_word_t r_mem [2**ADDR_W];

  always_ff @(posedge ck) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/nano_loader_mem.sv
// Byte-stream program loader that fills nano_ram from address 0, then releases
// the NanoCPU and serves its memory bus.
module nano_loader_mem
  import nano_pkg::*;
#(
  parameter int LOAD_WORDS = 256
) (
  input logic              ck,
  input logic              rst,
  nano_loader_mem_if.slave b_if
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LOAD_WORDS - 1);

  loader_state_t     r_state;
  loader_state_t     w_state_nxt;
  logic [ADDR_W-1:0] r_wptr;
  logic [7:0]        r_hi;
  logic              r_cpu_rst;
  logic              r_busy;
  logic              r_done;

  logic              w_byte_ready;
  logic              w_accept;
  logic              w_restart;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_waddr;
  mem_word_t         w_ram_wdata;

  always_comb begin
    w_state_nxt  = r_state;
    w_byte_ready = 1'b0;
    w_restart    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (b_if.load_start) begin
          w_state_nxt = LOAD_HI;
          w_restart   = 1'b1;
        end else if (b_if.run) begin
          w_state_nxt = RUN;
        end
      end
      LOAD_HI: begin
        w_byte_ready = 1'b1;
        if (b_if.byte_valid) w_state_nxt = LOAD_LO;
      end
      LOAD_LO: begin
        w_byte_ready = 1'b1;
        if (b_if.byte_valid) w_state_nxt = (r_wptr == LAST_ADDR) ? RUN : LOAD_HI;
      end
      RUN: begin
        if (b_if.load_start) begin
          w_state_nxt = LOAD_HI;
          w_restart   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = b_if.byte_valid & w_byte_ready;

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_wptr    <= '0;
      r_hi      <= '0;
      r_cpu_rst <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cpu_rst <= (r_state != RUN);
      r_busy    <= (r_state == LOAD_HI) || (r_state == LOAD_LO);
      r_done    <= (r_state == RUN);
      if (w_restart) begin
        r_wptr <= '0;
      end else if (w_accept && r_state == LOAD_LO) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_accept && r_state == LOAD_HI) r_hi <= b_if.byte_in;
    end
  end

  // The loader owns the write port while loading; the CPU only once released.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_waddr = b_if.address;
    w_ram_wdata = b_if.dataW;
    if (r_state == LOAD_LO) begin
      w_ram_we    = w_accept;
      w_ram_waddr = r_wptr;
      w_ram_wdata = {r_hi, b_if.byte_in};
    end else if (r_state == RUN) begin
      w_ram_we    = b_if.ce & b_if.we;
    end
  end

  nano_ram u_ram (
    .ck      (ck),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (b_if.address),
    .o_rdata (b_if.dataR)
  );

  assign b_if.byte_ready = w_byte_ready;
  assign b_if.busy       = r_busy;
  assign b_if.done       = r_done;
  assign b_if.cpu_rst    = r_cpu_rst;

endmodule
